ucie_ctl_sb_tx_arbiter: RTL and testbench
=========================================

# ucie_ctl_sb_tx_arbiter

Shares the single sideband transmit channel of the UCIe controller PHY between two requesters: the link-training state machine (4-bit sideband messages) and the RDI configuration path (NC-bit config words from lp_cfg). Sits between those sources and the PHY sideband output that drives the remote die. Round-robin arbitration, credit-based flow control against the remote receiver, and a drain sequence used before link reset/retrain.

## Interface
- NC, 32: sideband data width in bits.
- MSG_W, 4: training message width; MSG_W <= NC.
- CRD_MAX, 4: remote receive credits available after reset; >= 1.
- CW: localparam, $clog2(CRD_MAX+1).

- i_clk  in  1  sole clock; every flop on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ltsm_req  in  1  training requester has a message.
- i_ltsm_msg  in  MSG_W  training message, stable while i_ltsm_req is high and ungranted.
- o_ltsm_gnt  out  1  combinational grant; message accepted this cycle.
- i_cfg_valid  in  1  config requester has a word.
- i_cfg_data  in  NC  config word, stable while i_cfg_valid is high and not accepted.
- o_cfg_ready  out  1  combinational; word accepted when i_cfg_valid & o_cfg_ready.
- o_sb_data_valid  out  1  registered; one word on the channel this cycle.
- o_sb_data  out  NC  registered; message zero-extended to NC, or config word.
- o_sb_is_msg  out  1  registered; 1 = training message, 0 = config word.
- i_sb_crd_return  in  1  one-cycle pulse; remote returns one credit.
- i_flush_req  in  1  level; stop granting and wait for all credits back.
- o_flush_done  out  1  registered; high while drained and i_flush_req still high.
- o_crd_avail  out  CW  registered credit count.
- o_crd_overflow  out  1  sticky; credit returned while count was CRD_MAX.

## Operation
- FSM states: RUN, DRAIN, DONE. Reset state RUN.
  - RUN: arbitrate. i_flush_req=1 -> DRAIN; no grant in the cycle the transition is taken.
  - DRAIN: no grants. Credit count == CRD_MAX -> DONE. i_flush_req=0 -> RUN; this takes priority.
  - DONE: no grants; o_flush_done=1. i_flush_req=0 -> RUN.
- Grant eligibility: state RUN, i_flush_req=0, credit count > 0. At most one grant per cycle.
- Round-robin pointer (1 bit, reset = training):
  - Only one requester active: it wins.
  - Both active: the requester named by the pointer wins.
  - After any grant, the pointer moves to the other requester. No grant leaves the pointer unchanged.
- Credits:
  - Count resets to CRD_MAX and is decremented on each grant.
  - i_sb_crd_return increments it. A grant and a return in the same cycle leave it unchanged.
  - A return at CRD_MAX with no grant that cycle: count stays CRD_MAX and o_crd_overflow sets.
  - o_crd_overflow clears only on reset.
  - Count never underflows: eligibility forbids a grant at 0.
- Output register: loaded on a grant cycle with {zeros, msg} / 1, or cfg word / 0. o_sb_data_valid=1 for exactly the next cycle.
- No buffering: each requester holds its request until granted. A request may be dropped without being granted; no penalty.

## Timing
- Reset values:
  - o_sb_data_valid=0, o_sb_data=0, o_sb_is_msg=0.
  - o_crd_avail=CRD_MAX, o_crd_overflow=0, o_flush_done=0.
  - FSM=RUN, pointer=training.
  - Grants are 0 while i_rst_n=0.
- Latency: grant in cycle N -> word on o_sb_data with o_sb_data_valid in cycle N+1.
- Sustained throughput: 1 word/cycle while credits last.
- o_crd_avail reflects grants and returns of cycle N in cycle N+1.
- o_flush_done: rises one cycle after the DONE entry edge. Falls one cycle after i_flush_req deasserts.
- Asynchronous reset mid-transfer drops the in-flight word. All state returns to reset values immediately.

## Test plan
- Reset, CRD_MAX=4, i_ltsm_req=1 with msg=4'hA -> o_ltsm_gnt=1 in cycle 0. Cycle 1: o_sb_data=32'h0000000A, o_sb_is_msg=1, o_crd_avail=3.
- Both requesters held high, no returns, CRD_MAX=4 -> grant order ltsm, cfg, ltsm, cfg. Fifth cycle: no grant, o_crd_avail=0, o_sb_data_valid=0 the cycle after.
- Credits at 0, one i_sb_crd_return pulse with cfg pending -> o_crd_avail=1 next cycle. Cfg granted that cycle; o_crd_avail=0 after.
- Grant and i_sb_crd_return in the same cycle at count 2 -> count stays 2. Return at count 4 with no grant -> count 4, o_crd_overflow=1 and stays set.
- Four words sent, then i_flush_req=1 with cfg pending -> no grants. Four return pulses -> o_flush_done=1. Deassert i_flush_req -> o_flush_done=0; cfg granted in the first RUN cycle.
- Assert i_rst_n=0 in the cycle after a grant -> o_sb_data_valid=0 immediately, o_crd_avail=4, pointer=training.

Source files
------------

// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Sideband TX arbiter: round-robin between link-training messages and RDI config
// words, gated by remote receive credits, with a flush/drain handshake.
module ucie_ctl_sb_tx_arbiter #(
   parameter  int NC      = 32,
   parameter  int MSG_W   = 4,
   parameter  int CRD_MAX = 4,
   localparam int CW      = $clog2(CRD_MAX + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ltsm_req,
   input  logic [MSG_W-1:0] i_ltsm_msg,
   output logic             o_ltsm_gnt,
   input  logic             i_cfg_valid,
   input  logic [NC-1:0]    i_cfg_data,
   output logic             o_cfg_ready,
   output logic             o_sb_data_valid,
   output logic [NC-1:0]    o_sb_data,
   output logic             o_sb_is_msg,
   input  logic             i_sb_crd_return,
   input  logic             i_flush_req,
   output logic             o_flush_done,
   output logic [CW-1:0]    o_crd_avail,
   output logic             o_crd_overflow
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   localparam logic [CW-1:0] CRD_FULL = CW'(CRD_MAX);

   state_t        state, state_nxt;
   logic          ptr;        // 0 = training has priority on a tie, 1 = config
   logic [CW-1:0] crd;
   logic          eligible;
   logic          gnt_ltsm, gnt_cfg, gnt;

   // Reset is folded in so grants stay low while the block is held in reset.
   assign eligible = i_rst_n & (state == RUN) & ~i_flush_req & (crd != '0);
   assign gnt_ltsm = eligible & i_ltsm_req  & (~i_cfg_valid | ~ptr);
   assign gnt_cfg  = eligible & i_cfg_valid & (~i_ltsm_req  |  ptr);
   assign gnt      = gnt_ltsm | gnt_cfg;

   assign o_ltsm_gnt  = gnt_ltsm;
   assign o_cfg_ready = gnt_cfg;
   assign o_crd_avail = crd;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (i_flush_req) state_nxt = DRAIN;
         DRAIN:   if (!i_flush_req) state_nxt = RUN;
                  else if (crd == CRD_FULL) state_nxt = DONE;
         DONE:    if (!i_flush_req) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= RUN;
         o_flush_done <= 1'b0;
      end else begin
         state        <= state_nxt;
         o_flush_done <= (state == DONE) & i_flush_req;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  ptr <= 1'b0;
      else if (gnt)  ptr <= gnt_ltsm;
   end

   // A grant and a return in the same cycle cancel; a lone return at full
   // count is a remote protocol error and is latched until reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         crd            <= CRD_FULL;
         o_crd_overflow <= 1'b0;
      end else if (gnt && !i_sb_crd_return) begin
         crd <= crd - CW'(1);
      end else if (!gnt && i_sb_crd_return) begin
         if (crd == CRD_FULL) o_crd_overflow <= 1'b1;
         else                 crd <= crd + CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_sb_data_valid <= 1'b0;
         o_sb_data       <= '0;
         o_sb_is_msg     <= 1'b0;
      end else begin
         o_sb_data_valid <= gnt;
         if (gnt_ltsm) begin
            o_sb_data   <= NC'(i_ltsm_msg);
            o_sb_is_msg <= 1'b1;
         end else if (gnt_cfg) begin
            o_sb_data   <= i_cfg_data;
            o_sb_is_msg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arbiter.sv
// Bench for ucie_ctl_sb_tx_arbiter: cycle model predicts grants and counters,
// scoreboard queue holds words expected on the sideband output.
module tb_ucie_ctl_sb_tx_arbiter;
   localparam int NC = 32, MSG_W = 4, CRD_MAX = 4;
   localparam int CW = $clog2(CRD_MAX + 1);

   typedef struct packed {
      logic          is_msg;
      logic [NC-1:0] data;
   } word_t;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             ltsm_req = 1'b0, cfg_valid = 1'b0;
   logic [MSG_W-1:0] ltsm_msg = '0;
   logic [NC-1:0]    cfg_data = '0;
   logic             crd_ret = 1'b0, flush_req = 1'b0;
   logic             ltsm_gnt, cfg_ready, sb_valid, sb_is_msg, flush_done, crd_ovf;
   logic [NC-1:0]    sb_data;
   logic [CW-1:0]    crd_avail;

   ucie_ctl_sb_tx_arbiter #(.NC(NC), .MSG_W(MSG_W), .CRD_MAX(CRD_MAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ltsm_req(ltsm_req), .i_ltsm_msg(ltsm_msg), .o_ltsm_gnt(ltsm_gnt),
      .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data), .o_cfg_ready(cfg_ready),
      .o_sb_data_valid(sb_valid), .o_sb_data(sb_data), .o_sb_is_msg(sb_is_msg),
      .i_sb_crd_return(crd_ret), .i_flush_req(flush_req), .o_flush_done(flush_done),
      .o_crd_avail(crd_avail), .o_crd_overflow(crd_ovf)
   );

   always #5 clk = ~clk;

   int    n_chk = 0, n_err = 0;
   word_t sb_q[$];
   int    m_crd = CRD_MAX, m_st = 0;   // m_st: 0 RUN, 1 DRAIN, 2 DONE
   logic  m_ptr = 1'b0, m_ovf = 1'b0, m_fd = 1'b0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_crd = CRD_MAX; m_st = 0; m_ptr = 1'b0; m_ovf = 1'b0; m_fd = 1'b0;
      sb_q.delete();
   endtask

   // Called just after a negedge with this cycle's inputs already driven.
   task automatic cyc();
      logic  el, gl, gc;
      word_t w;
      #4;
      el = (m_st == 0) && !flush_req && (m_crd != 0);
      gl = el && ltsm_req  && (!cfg_valid || !m_ptr);
      gc = el && cfg_valid && (!ltsm_req  ||  m_ptr);
      chk("ltsm_gnt", ltsm_gnt, gl);
      chk("cfg_ready", cfg_ready, gc);
      chk("sb_valid", sb_valid, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
         w = sb_q.pop_front();
         if (sb_valid) begin
            chk("sb_data", sb_data, w.data);
            chk("sb_is_msg", sb_is_msg, w.is_msg);
         end
      end
      chk("crd_avail", crd_avail, m_crd);
      chk("crd_ovf", crd_ovf, m_ovf);
      chk("flush_done", flush_done, m_fd);
      if (gl) sb_q.push_back('{is_msg: 1'b1, data: NC'(ltsm_msg)});
      if (gc) sb_q.push_back('{is_msg: 1'b0, data: cfg_data});
      m_fd = (m_st == 2) && flush_req;
      case (m_st)
         0: if (flush_req) m_st = 1;
         1: if (!flush_req) m_st = 0; else if (m_crd == CRD_MAX) m_st = 2;
         default: if (!flush_req) m_st = 0;
      endcase
      if (crd_ret && !(gl || gc) && m_crd == CRD_MAX) m_ovf = 1'b1;
      else m_crd = m_crd - int'(gl || gc) + int'(crd_ret);
      if (gl || gc) m_ptr = gl;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_sb_valid", sb_valid, 1'b0);
      chk("rst_sb_data", sb_data, '0);
      chk("rst_is_msg", sb_is_msg, 1'b0);
      chk("rst_crd", crd_avail, CRD_MAX);
      chk("rst_ovf", crd_ovf, 1'b0);
      chk("rst_fd", flush_done, 1'b0);
      chk("rst_ltsm_gnt", ltsm_gnt, 1'b0);
      chk("rst_cfg_ready", cfg_ready, 1'b0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset with both requesters pending: no grant may leak out.
      ltsm_req = 1'b1; cfg_valid = 1'b1;
      @(negedge clk);
      do_reset();
      ltsm_req = 1'b0; cfg_valid = 1'b0;
      chk("post_rst_crd", crd_avail, CRD_MAX);

      // First training message: granted in cycle 0, visible in cycle 1.
      ltsm_req = 1'b1; ltsm_msg = 4'hA;
      cyc();
      ltsm_req = 1'b0;
      chk("first_data", sb_data, 32'h0000000A);
      chk("first_is_msg", sb_is_msg, 1'b1);
      chk("first_crd", crd_avail, 3);
      cyc();

      // Both requesters held, fresh pointer: ltsm, cfg, ltsm, cfg, then stall.
      do_reset();
      ltsm_req = 1'b1; cfg_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ltsm_msg = MSG_W'(i + 3);
         cfg_data = 32'hC0DE_0000 + NC'(i);
         cyc();
      end
      chk("drained_crd", crd_avail, 0);
      ltsm_req = 1'b0;
      cyc();
      chk("stall_valid", sb_valid, 1'b0);

      // Zero credits, cfg pending, one return admits exactly one word.
      cfg_data = 32'hDEAD_BEEF;
      crd_ret = 1'b1; cyc(); crd_ret = 1'b0;
      chk("ret_crd", crd_avail, 1);
      cyc();
      cfg_data = 32'h1234_5678;
      cyc();
      cfg_valid = 1'b0;
      chk("after_ret_crd", crd_avail, 0);

      // Simultaneous grant and return hold the count; return at full overflows.
      crd_ret = 1'b1; cyc(); cyc(); crd_ret = 1'b0;
      ltsm_req = 1'b1; ltsm_msg = 4'h7; crd_ret = 1'b1;
      cyc();
      ltsm_req = 1'b0;
      chk("gnt_ret_crd", crd_avail, 2);
      cyc(); cyc(); cyc();
      crd_ret = 1'b0;
      chk("full_crd", crd_avail, CRD_MAX);
      chk("ovf_set", crd_ovf, 1'b1);
      for (int i = 0; i < 3; i++) cyc();
      chk("ovf_sticky", crd_ovf, 1'b1);

      // Flush: burn all credits, then drain while cfg waits.
      do_reset();
      ltsm_req = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hAAAA_0001; ltsm_msg = 4'h1;
      for (int i = 0; i < 4; i++) cyc();
      ltsm_req = 1'b0; flush_req = 1'b1; cfg_data = 32'hF1F1_F1F1;
      cyc(); cyc();
      crd_ret = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      crd_ret = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      chk("flush_done_hi", flush_done, 1'b1);
      flush_req = 1'b0;
      cyc();
      chk("flush_done_lo", flush_done, 1'b0);
      cyc(); cyc();
      cfg_valid = 1'b0;

      // Async reset right after a training grant drops the in-flight word.
      ltsm_req = 1'b1; ltsm_msg = 4'h9;
      cyc();
      ltsm_req = 1'b0;
      chk("pre_rst_valid", sb_valid, 1'b1);
      do_reset();
      ltsm_req = 1'b1; cfg_valid = 1'b1; cfg_data = 32'h5555_AAAA;
      #4;
      chk("ptr_after_rst", ltsm_gnt, 1'b1);
      #1;
      @(negedge clk);
      do_reset();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         ltsm_req  = ($urandom_range(0, 3) != 0);
         cfg_valid = ($urandom_range(0, 3) != 0);
         ltsm_msg  = MSG_W'($urandom);
         cfg_data  = NC'($urandom);
         crd_ret   = ($urandom_range(0, 2) == 0) && (m_crd < CRD_MAX);
         if ($urandom_range(0, 29) == 0) flush_req = ~flush_req;
         cyc();
      end
      ltsm_req = 1'b0; cfg_valid = 1'b0; crd_ret = 1'b0; flush_req = 1'b0;
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
